vram_painter: RTL
=================

// Module: vram_painter
// PURPOSE
// Parametrised VRAM write controller between the touch controller(s) and the block_ram VRAM.
// - On reset, and on request, fills the whole frame with CLEAR_COLOR.
// - Serves N_TOUCH touch channels round-robin.
// - Paints a clipped square brush of radius BRUSH_R around each touch in pen or erase colour.
// - Issues one VRAM write per enabled cycle; the display controller reads VRAM independently.
// PARAMETERS
// DISPLAY_WIDTH  240     pixels per row (x range 0..W-1)
// DISPLAY_HEIGHT 320     rows (y range 0..H-1)
// VRAM_W         16      colour word width
// N_TOUCH        2       touch channels arbitrated
// BRUSH_R        1       brush radius; window is (2R+1)x(2R+1) before clipping; 0 = single pixel
// CLEAR_COLOR    16'h0000  fill colour for clear and erase (BLACK)
// CW             9       touch coordinate width
// PORTS
// clk          in   1            system clock
// rst          in   1            asynchronous reset, active high
// ena          in   1            low = freeze: no writes, all state and counters hold
// touch_valid  in   N_TOUCH      per-channel touch present
// touch_x      in   N_TOUCH*CW   per-channel x, channel i at [i*CW +: CW]
// touch_y      in   N_TOUCH*CW   per-channel y, same packing
// pen_color    in   VRAM_W       paint colour
// erase        in   1            1 = paint with CLEAR_COLOR; sampled when a touch is accepted
// clear_req    in   1            request full-frame clear (level, sampled each cycle)
// vram_wr_ena  out  1            VRAM write strobe
// vram_wr_addr out  $clog2(W*H)  write address = y*DISPLAY_WIDTH + x
// vram_wr_data out  VRAM_W       write data
// busy         out  1            high in S_CLEAR or S_PAINT
// clear_done   out  1            one-cycle pulse after the last clear write
// BEHAVIOUR
// Reset state: S_CLEAR, clear counter 0, wr_ena/addr/data 0, busy 1, clear_done 0.
// Reset also clears: rr pointer (channel 0 first), clear-pending flag, last-point valid bits.
// All outputs are registered. Async rst mid-operation: wr_ena drops immediately; the clear restarts at address 0.
// S_CLEAR: one write per enabled cycle, addr 0..W*H-1 ascending, data CLEAR_COLOR.
//   - After addr W*H-1 -> S_IDLE; clear_done pulses in the following cycle.
//   - clear_req is ignored in this state.
// S_IDLE: clear_req, or a pending clear -> S_CLEAR; clear has priority over touch. Else go to acceptance below.
// Acceptance: if any touch_valid, rr arbiter grants the first valid channel after the last grant.
//   - Latch x,y clamped (x>=W -> W-1; y>=H -> H-1).
//   - Latch colour = erase ? CLEAR_COLOR : pen_color.
// Dedup: if clamped point and colour equal that channel's last painted point, drop it.
//   - The grant still advances the rr pointer; stay in S_IDLE.
// Otherwise compute window: x0=max(x-R,0), x1=min(x+R,W-1); same for y0/y1.
//   - Go to S_PAINT. The first write appears the cycle after acceptance.
// S_PAINT: raster order y0..y1 outer, x0..x1 inner, one write per enabled cycle.
//   - The row base is advanced by +W; no multiplier in the loop.
//   - After writing (x1,y1) -> S_IDLE and record the last point for the channel.
//   - clear_req during S_PAINT sets a pending flag; the brush completes, then the clear runs.
// ena low: wr_ena 0 for that cycle; resumes exactly at the next address. Arithmetic is unsigned.
//   - x-R is computed at CW+1 bits to detect underflow.
// STRUCTURE
// - Package vram_painter_pkg holds the state_t enum {S_CLEAR,S_IDLE,S_PAINT} and the addr width function.
// - Colours come from the ili9341 defines (ILI9341_color_t, BLACK, WHITE).
// - Sub-module rr_arbiter #(N): request vector + advance strobe -> one-hot grant + index.
// TESTING (W=8, H=6, R=1, N_TOUCH=2)
// - Reset release: exactly 48 writes, addr 0..47, data 16'h0000; clear_done on the cycle after addr 47; busy then 0.
// - ch0 (3,2), pen 16'hFFFF: writes to 10,11,12,18,19,20,26,27,28 in that order, then idle.
// - Clip: (0,0) -> addrs 0,1,8,9. Clamp: (20,9) -> (7,5) -> addrs 38,39,46,47.
// - Holding the point repeats nothing.
// - ch0 (1,1) and ch1 (6,4) both valid: ch0 window (0,1,2,8..10,16..18) then ch1 window (29..31,37..39,45..47).
// - Held thereafter: no further writes.
// - erase=1 at (3,2): 9 writes of 16'h0000.
// - clear_req pulse during the 4th paint write: remaining 5 writes, then the 48-write clear.
// - ena low 5 cycles at clear addr 20: no writes, resumes at 20.
// - rst mid-paint: wr_ena 0 at once; the clear restarts at 0.

Source files
------------

// File: rtl/vram_painter_pkg.sv
// Shared types and helpers for the VRAM painter: FSM states, ILI9341 colours,
// and the address-width calculation used for port sizing.
package vram_painter_pkg;

    typedef logic [15:0] ILI9341_color_t;

    localparam ILI9341_color_t BLACK = 16'h0000;
    localparam ILI9341_color_t WHITE = 16'hFFFF;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_PAINT
    } state_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        while ((64'(1) << w) < 64'(depth)) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/vram_painter_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel at or after the
// priority pointer; the pointer moves past the granted channel on advance.
module rr_arbiter
    import vram_painter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pri_q;
    logic [IW-1:0] pri_d;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(pri_q) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
        pri_d = pri_q;
        if (adv && found) begin
            pri_d = (32'(idx) == N - 1) ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q <= '0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/vram_painter.sv
// VRAM write controller: full-frame clear on reset/request, then round-robin
// painting of a clipped square brush around each accepted touch point.
module vram_painter
    import vram_painter_pkg::*;
#(
    parameter int unsigned       DISPLAY_WIDTH  = 240,
    parameter int unsigned       DISPLAY_HEIGHT = 320,
    parameter int unsigned       VRAM_W         = 16,
    parameter int unsigned       N_TOUCH        = 2,
    parameter int unsigned       BRUSH_R        = 1,
    parameter logic [VRAM_W-1:0] CLEAR_COLOR    = VRAM_W'(BLACK),
    parameter int unsigned       CW             = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [N_TOUCH-1:0]      touch_valid,
    input  logic [N_TOUCH*CW-1:0]   touch_x,
    input  logic [N_TOUCH*CW-1:0]   touch_y,
    input  logic [VRAM_W-1:0]       pen_color,
    input  logic                    erase,
    input  logic                    clear_req,
    output logic                    vram_wr_ena,
    output logic [addr_width(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] vram_wr_addr,
    output logic [VRAM_W-1:0]       vram_wr_data,
    output logic                    busy,
    output logic                    clear_done
);

    localparam int unsigned AW = addr_width(DISPLAY_WIDTH * DISPLAY_HEIGHT);
    localparam int unsigned IW = (N_TOUCH > 1) ? $clog2(N_TOUCH) : 1;

    typedef logic [CW:0]   cx_t;
    typedef logic [AW-1:0] addr_t;

    localparam cx_t   XMAX      = cx_t'(DISPLAY_WIDTH - 1);
    localparam cx_t   YMAX      = cx_t'(DISPLAY_HEIGHT - 1);
    localparam cx_t   RAD       = cx_t'(BRUSH_R);
    localparam addr_t LAST_ADDR = addr_t'(DISPLAY_WIDTH * DISPLAY_HEIGHT - 1);
    localparam addr_t ROW_STEP  = addr_t'(DISPLAY_WIDTH);

    state_t            state_q, state_d;
    addr_t             cnt_q, cnt_d;
    addr_t             row_q, row_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic [CW-1:0]     x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]     px_q, px_d, py_q, py_d;
    logic [VRAM_W-1:0] color_q, color_d;
    logic [IW-1:0]     chan_q, chan_d;
    logic              clear_pend_q, clear_pend_d;
    logic              done_pend_q, done_pend_d;

    logic [N_TOUCH-1:0][CW-1:0]     last_x_q, last_x_d;
    logic [N_TOUCH-1:0][CW-1:0]     last_y_q, last_y_d;
    logic [N_TOUCH-1:0][VRAM_W-1:0] last_c_q, last_c_d;
    logic [N_TOUCH-1:0]             last_v_q, last_v_d;

    logic              wr_ena_q, wr_ena_d;
    addr_t             wr_addr_q, wr_addr_d;
    logic [VRAM_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              clear_done_q, clear_done_d;

    logic [N_TOUCH-1:0] grant;
    logic [IW-1:0]      gidx;
    logic               adv;

    cx_t               tx, ty, cx, cy, xm, xp, ym, yp;
    logic [CW-1:0]     ax0, ax1, ay0, ay1;
    logic [VRAM_W-1:0] acc_color;
    logic              dup;

    rr_arbiter #(
        .N  (N_TOUCH),
        .IW (IW)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (touch_valid),
        .adv   (adv),
        .grant (grant),
        .idx   (gidx)
    );

    // Candidate point for the granted channel; x-R is kept one bit wider so
    // the top bit flags underflow at the left/top edge.
    always_comb begin
        tx  = {1'b0, touch_x[gidx*CW +: CW]};
        ty  = {1'b0, touch_y[gidx*CW +: CW]};
        cx  = (tx > XMAX) ? XMAX : tx;
        cy  = (ty > YMAX) ? YMAX : ty;
        xm  = cx - RAD;
        xp  = cx + RAD;
        ym  = cy - RAD;
        yp  = cy + RAD;
        ax0 = xm[CW] ? '0 : xm[CW-1:0];
        ay0 = ym[CW] ? '0 : ym[CW-1:0];
        ax1 = (xp > XMAX) ? XMAX[CW-1:0] : xp[CW-1:0];
        ay1 = (yp > YMAX) ? YMAX[CW-1:0] : yp[CW-1:0];
        acc_color = erase ? CLEAR_COLOR : pen_color;
        dup = last_v_q[gidx] && (last_x_q[gidx] == cx[CW-1:0]) &&
              (last_y_q[gidx] == cy[CW-1:0]) && (last_c_q[gidx] == acc_color);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        x_d          = x_q;
        y_d          = y_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        px_d         = px_q;
        py_d         = py_q;
        color_d      = color_q;
        chan_d       = chan_q;
        clear_pend_d = clear_pend_q;
        done_pend_d  = done_pend_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        last_c_d     = last_c_q;
        last_v_d     = last_v_q;
        wr_ena_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        clear_done_d = 1'b0;
        adv          = 1'b0;

        if (ena) begin
            clear_done_d = done_pend_q;
            done_pend_d  = 1'b0;
            unique case (state_q)
                S_CLEAR: begin
                    wr_ena_d  = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = CLEAR_COLOR;
                    if (cnt_q == LAST_ADDR) begin
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        done_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + addr_t'(1);
                    end
                end
                S_IDLE: begin
                    if (clear_req || clear_pend_q) begin
                        state_d      = S_CLEAR;
                        cnt_d        = '0;
                        clear_pend_d = 1'b0;
                    end else if (|grant) begin
                        adv = 1'b1;
                        if (!dup) begin
                            state_d = S_PAINT;
                            chan_d  = gidx;
                            px_d    = cx[CW-1:0];
                            py_d    = cy[CW-1:0];
                            color_d = acc_color;
                            x_d     = ax0;
                            x0_d    = ax0;
                            x1_d    = ax1;
                            y_d     = ay0;
                            y1_d    = ay1;
                            row_d   = addr_t'(ay0) * ROW_STEP;
                        end
                    end
                end
                S_PAINT: begin
                    wr_ena_d  = 1'b1;
                    wr_addr_d = row_q + addr_t'(x_q);
                    wr_data_d = color_q;
                    if (clear_req) begin
                        clear_pend_d = 1'b1;
                    end
                    // Row base steps by the display width so the raster loop needs no multiply.
                    if (x_q == x1_q) begin
                        if (y_q == y1_q) begin
                            state_d          = S_IDLE;
                            last_x_d[chan_q] = px_q;
                            last_y_d[chan_q] = py_q;
                            last_c_d[chan_q] = color_q;
                            last_v_d[chan_q] = 1'b1;
                        end else begin
                            x_d   = x0_q;
                            y_d   = y_q + CW'(1);
                            row_d = row_q + ROW_STEP;
                        end
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
                default: state_d = S_CLEAR;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            row_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            x0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            px_q         <= '0;
            py_q         <= '0;
            color_q      <= '0;
            chan_q       <= '0;
            clear_pend_q <= 1'b0;
            done_pend_q  <= 1'b0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            last_c_q     <= '0;
            last_v_q     <= '0;
            wr_ena_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b1;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            x_q          <= x_d;
            y_q          <= y_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            px_q         <= px_d;
            py_q         <= py_d;
            color_q      <= color_d;
            chan_q       <= chan_d;
            clear_pend_q <= clear_pend_d;
            done_pend_q  <= done_pend_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            last_c_q     <= last_c_d;
            last_v_q     <= last_v_d;
            wr_ena_q     <= wr_ena_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign vram_wr_ena  = wr_ena_q;
    assign vram_wr_addr = wr_addr_q;
    assign vram_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign clear_done   = clear_done_q;

endmodule
